// File: rtl/design_01_sched.sv
// Round-robin scheduler that shares one mkDesign_01 instance among NREQ requesters,
// sequencing start -> result -> check for each granted transaction.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no owner; arbitrate and latch the winner's arguments
// S_START  | drive start args, fire stenable when RDY_start is high
// S_RESULT | drive result_c, capture result when RDY_result is high
// S_CHECK  | drive check_d, fire chenable and capture check on RDY_check
// S_FIN    | done pulse to the owner, grant released on exit
module design_01_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [5*NREQ-1:0] req_a,
    input  logic [5*NREQ-1:0] req_b,
    input  logic [5*NREQ-1:0] req_c,
    input  logic [5*NREQ-1:0] req_d,
    output logic [NREQ-1:0]   grant,
    output logic              done,
    output logic              err,
    output logic [4:0]        rsp_result,
    output logic [4:0]        rsp_check,
    output logic [4:0]        start_a,
    output logic [4:0]        start_b,
    output logic              stenable,
    input  logic              RDY_start,
    output logic [4:0]        result_c,
    input  logic [4:0]        result,
    input  logic              RDY_result,
    output logic [4:0]        check_d,
    output logic              chenable,
    input  logic [4:0]        check,
    input  logic              RDY_check
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RESULT = 3'd2,
        S_CHECK  = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    // Abort fires on the edge where the wait count would reach TIMEOUT.
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      rr_q;
    logic [1:0]      rr_next;
    logic [7:0]      timer_q;
    logic [4:0]      lat_a;
    logic [4:0]      lat_b;
    logic [4:0]      lat_c;
    logic [4:0]      lat_d;

    logic            win_found;
    logic [1:0]      win_idx;
    logic [NREQ-1:0] win_onehot;
    logic [4:0]      sel_a;
    logic [4:0]      sel_b;
    logic [4:0]      sel_c;
    logic [4:0]      sel_d;

    logic            grant_load;
    logic            grant_clear;
    logic            timer_inc;
    logic            take_result;
    logic            take_check;
    logic            abort;

    // First requester at or after the rr pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[(int'(rr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = 2'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        sel_a      = 5'd0;
        sel_b      = 5'd0;
        sel_c      = 5'd0;
        sel_d      = 5'd0;
        for (int k = 0; k < NREQ; k++) begin
            win_onehot[k] = win_found && (int'(win_idx) == k);
            if (int'(win_idx) == k) begin
                sel_a = req_a[5*k +: 5];
                sel_b = req_b[5*k +: 5];
                sel_c = req_c[5*k +: 5];
                sel_d = req_d[5*k +: 5];
            end
        end
        rr_next = (int'(win_idx) == NREQ - 1) ? 2'd0 : win_idx + 2'd1;
    end

    always_comb begin
        state_d     = state_q;
        stenable    = 1'b0;
        chenable    = 1'b0;
        start_a     = 5'd0;
        start_b     = 5'd0;
        result_c    = 5'd0;
        check_d     = 5'd0;
        done        = 1'b0;
        grant_load  = 1'b0;
        grant_clear = 1'b0;
        timer_inc   = 1'b0;
        take_result = 1'b0;
        take_check  = 1'b0;
        abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_load = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                start_a = lat_a;
                start_b = lat_b;
                if (RDY_start) begin
                    stenable = 1'b1;
                    state_d  = S_RESULT;
                end else if (timer_q == TLAST) begin
                    abort = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_RESULT: begin
                result_c = lat_c;
                if (RDY_result) begin
                    take_result = 1'b1;
                    state_d     = S_CHECK;
                end else if (timer_q == TLAST) begin
                    abort = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_CHECK: begin
                check_d = lat_d;
                if (RDY_check) begin
                    chenable   = 1'b1;
                    take_check = 1'b1;
                    state_d    = S_FIN;
                end else if (timer_q == TLAST) begin
                    abort = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                grant_clear = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                grant_clear = 1'b1;
                state_d     = S_IDLE;
            end
        endcase

        // Aborting releases the owner on the same edge err is registered.
        if (abort) begin
            grant_clear = 1'b1;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            grant      <= '0;
            err        <= 1'b0;
            rr_q       <= 2'd0;
            timer_q    <= 8'd0;
            lat_a      <= 5'd0;
            lat_b      <= 5'd0;
            lat_c      <= 5'd0;
            lat_d      <= 5'd0;
            rsp_result <= 5'd0;
            rsp_check  <= 5'd0;
        end else begin
            state_q <= state_d;
            err     <= abort;

            if (grant_load) begin
                grant <= win_onehot;
                rr_q  <= rr_next;
                lat_a <= sel_a;
                lat_b <= sel_b;
                lat_c <= sel_c;
                lat_d <= sel_d;
            end else if (grant_clear) begin
                grant <= '0;
            end

            if (state_d != state_q) begin
                timer_q <= 8'd0;
            end else if (timer_inc) begin
                timer_q <= timer_q + 8'd1;
            end

            if (take_result) begin
                rsp_result <= result;
            end
            if (take_check) begin
                rsp_check <= check;
            end
        end
    end

endmodule

// File: tb/tb_design_01_sched.sv
// Self-checking bench for design_01_sched: directed scenarios with a queue of
// expected completions, plus a small model of the shared design's datapath.
module tb_design_01_sched;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req;
    logic [9:0]  req_a, req_b, req_c, req_d;
    logic [1:0]  grant;
    logic        done, err;
    logic [4:0]  rsp_result, rsp_check;
    logic [4:0]  start_a, start_b, result_c, check_d;
    logic        stenable, chenable;
    logic        RDY_start, RDY_result, RDY_check;
    logic [4:0]  result, check;

    logic        use_model;
    logic [4:0]  fix_result, fix_check;
    logic [4:0]  cap_ab = 5'd0;

    typedef struct {
        logic [1:0] g;
        logic [4:0] r;
        logic [4:0] c;
        bit         is_err;
    } exp_t;

    exp_t sb[$];
    int   m_rr = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   viol = 0;

    design_01_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .req(req),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .grant(grant), .done(done), .err(err),
        .rsp_result(rsp_result), .rsp_check(rsp_check),
        .start_a(start_a), .start_b(start_b), .stenable(stenable), .RDY_start(RDY_start),
        .result_c(result_c), .result(result), .RDY_result(RDY_result),
        .check_d(check_d), .chenable(chenable), .check(check), .RDY_check(RDY_check)
    );

    always #5 CLK = ~CLK;

    // Model of the shared design: result = a+b+c, check = (a+b)^d.
    always @(posedge CLK) if (stenable) cap_ab <= start_a + start_b;
    assign result = use_model ? (cap_ab + result_c) : fix_result;
    assign check  = use_model ? (cap_ab ^ check_d) : fix_check;

    always @(negedge CLK) begin
        #3;
        if ((stenable && chenable) || ((stenable || chenable) && grant == 2'b00)) viol++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic set_args(input int i, input logic [4:0] a, b, c, d);
        req_a[5*i +: 5] = a;
        req_b[5*i +: 5] = b;
        req_c[5*i +: 5] = c;
        req_d[5*i +: 5] = d;
    endtask

    task automatic push_exp(input logic [1:0] rq, input bit is_err,
                            input logic [4:0] r0, c0, r1, c1);
        int   w;
        exp_t e;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_rr + k) % NREQ;
            if (w < 0 && rq[j]) w = j;
        end
        m_rr     = (w + 1) % NREQ;
        e.g      = (w == 0) ? 2'b01 : 2'b10;
        e.r      = (w == 0) ? r0 : r1;
        e.c      = (w == 0) ? c0 : c1;
        e.is_err = is_err;
        sb.push_back(e);
    endtask

    task automatic wait_end(input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(done || err) && n < maxc);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({grant, done, err, stenable, chenable, start_a, start_b, result_c, check_d,
             rsp_result, rsp_check} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: grant=%b done=%b err=%b st=%b ch=%b rsp=%0d/%0d, expected all 0",
                     grant, done, err, stenable, chenable, rsp_result, rsp_check);
        end
        RST = 1'b0;
        tick();
        n_tests++;
        if ({grant, done, err, stenable, chenable} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_release: grant=%b done=%b err=%b st=%b ch=%b, expected all 0",
                     grant, done, err, stenable, chenable);
        end
    endtask

    task automatic test_single();
        exp_t e;
        set_args(0, 5'd3, 5'd4, 5'd5, 5'd6);
        fix_result = 5'd9;
        fix_check  = 5'd12;
        req = 2'b01;
        push_exp(req, 1'b0, 5'd9, 5'd12, 5'd9, 5'd12);
        tick();
        n_tests++;
        if ({grant, stenable, start_a, start_b} !== {2'b01, 1'b1, 5'd3, 5'd4}) begin
            n_fail++;
            $display("FAIL t1_start: grant=%b st=%b a=%0d b=%0d, expected 01 1 3 4",
                     grant, stenable, start_a, start_b);
        end
        tick();
        n_tests++;
        if ({stenable, chenable, result_c} !== {1'b0, 1'b0, 5'd5}) begin
            n_fail++;
            $display("FAIL t1_result: st=%b ch=%b result_c=%0d, expected 0 0 5",
                     stenable, chenable, result_c);
        end
        tick();
        n_tests++;
        if ({chenable, check_d, done} !== {1'b1, 5'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL t1_check: ch=%b check_d=%0d done=%b, expected 1 6 0",
                     chenable, check_d, done);
        end
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({done, err, grant, rsp_result, rsp_check} !== {1'b1, 1'b0, e.g, e.r, e.c}) begin
            n_fail++;
            $display("FAIL t1_done: done=%b err=%b grant=%b rsp=%0d/%0d, expected 1 0 %b %0d/%0d",
                     done, err, grant, rsp_result, rsp_check, e.g, e.r, e.c);
        end
        req = 2'b00;
        tick();
        n_tests++;
        if ({done, grant} !== 3'd0) begin
            n_fail++;
            $display("FAIL t1_release: done=%b grant=%b, expected 0 00", done, grant);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   st_cnt;
        st_cnt    = 0;
        RDY_start = 1'b0;
        req = 2'b01;
        push_exp(req, 1'b0, 5'd9, 5'd12, 5'd9, 5'd12);
        for (int c = 2; c <= 7; c++) begin
            tick();
            st_cnt += int'(stenable);
        end
        tick();
        RDY_start = 1'b1;
        #1;
        n_tests++;
        if (stenable !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_rise: stenable=%b in RDY_start rise cycle, expected 1", stenable);
        end
        st_cnt += int'(stenable);
        tick();
        st_cnt += int'(stenable);
        tick();
        st_cnt += int'(stenable);
        tick();
        st_cnt += int'(stenable);
        n_tests++;
        if (st_cnt !== 1) begin
            n_fail++;
            $display("FAIL t3_once: stenable high %0d cycles, expected 1", st_cnt);
        end
        e = sb.pop_front();
        n_tests++;
        if ({done, grant, rsp_result, rsp_check} !== {1'b1, e.g, e.r, e.c}) begin
            n_fail++;
            $display("FAIL t3_done: done=%b (cycle 11) grant=%b rsp=%0d/%0d, expected 1 %b %0d/%0d",
                     done, grant, rsp_result, rsp_check, e.g, e.r, e.c);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        int   ch_cnt, early, n;
        ch_cnt     = 0;
        early      = 0;
        RDY_check  = 1'b0;
        fix_result = 5'd9;
        fix_check  = 5'd20;
        req = 2'b01;
        push_exp(req, 1'b1, 5'd9, 5'd12, 5'd9, 5'd12);
        repeat (3) tick();
        for (int c = 0; c < TIMEOUT; c++) begin
            ch_cnt += int'(chenable);
            early  += int'(err) + int'(done);
            tick();
        end
        e = sb.pop_front();
        n_tests++;
        if ({err, done, grant, chenable} !== {1'b1, 1'b0, 2'b00, 1'b0} || !e.is_err) begin
            n_fail++;
            $display("FAIL t4_err: err=%b done=%b grant=%b ch=%b, expected 1 0 00 0", err, done, grant, chenable);
        end
        n_tests++;
        if (ch_cnt !== 0 || early !== 0) begin
            n_fail++;
            $display("FAIL t4_wait: chenable count=%0d early err/done=%0d, expected 0 0", ch_cnt, early);
        end
        n_tests++;
        if ({rsp_result, rsp_check} !== {5'd9, 5'd12}) begin
            n_fail++;
            $display("FAIL t4_rsp: rsp=%0d/%0d, expected 9/12", rsp_result, rsp_check);
        end
        req = 2'b00;
        tick();
        RDY_check = 1'b1;
        fix_check = 5'd17;
        req = 2'b01;
        push_exp(req, 1'b0, 5'd9, 5'd17, 5'd9, 5'd17);
        wait_end(20, n);
        e = sb.pop_front();
        n_tests++;
        if ({done, err, grant, rsp_result, rsp_check} !== {1'b1, 1'b0, e.g, e.r, e.c} || n != 4) begin
            n_fail++;
            $display("FAIL t4_next: done=%b err=%b grant=%b rsp=%0d/%0d after %0d cycles, expected 1 0 %b %0d/%0d after 4",
                     done, err, grant, rsp_result, rsp_check, n, e.g, e.r, e.c);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_arg_latch();
        exp_t e;
        fix_result = 5'd9;
        fix_check  = 5'd12;
        set_args(0, 5'd3, 5'd4, 5'd5, 5'd6);
        req = 2'b01;
        push_exp(req, 1'b0, 5'd9, 5'd12, 5'd9, 5'd12);
        tick();
        set_args(0, 5'd1, 5'd2, 5'd7, 5'd9);
        #1;
        n_tests++;
        if ({start_a, start_b} !== {5'd3, 5'd4}) begin
            n_fail++;
            $display("FAIL t5_start: a=%0d b=%0d, expected 3 4", start_a, start_b);
        end
        tick();
        n_tests++;
        if (result_c !== 5'd5) begin
            n_fail++;
            $display("FAIL t5_result_c: result_c=%0d, expected 5", result_c);
        end
        tick();
        n_tests++;
        if (check_d !== 5'd6) begin
            n_fail++;
            $display("FAIL t5_check_d: check_d=%0d, expected 6", check_d);
        end
        tick();
        e = sb.pop_front();
        n_tests++;
        if ({done, grant, rsp_result, rsp_check} !== {1'b1, e.g, e.r, e.c}) begin
            n_fail++;
            $display("FAIL t5_done: done=%b grant=%b rsp=%0d/%0d, expected 1 %b %0d/%0d",
                     done, grant, rsp_result, rsp_check, e.g, e.r, e.c);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        RDY_result = 1'b0;
        set_args(0, 5'd3, 5'd4, 5'd5, 5'd6);
        req = 2'b01;
        push_exp(req, 1'b0, 5'd9, 5'd12, 5'd9, 5'd12);
        repeat (2) tick();
        RST = 1'b1;
        #1;
        void'(sb.pop_front());
        m_rr = 0;
        n_tests++;
        if ({grant, done, err, stenable, chenable, start_a, start_b, result_c, check_d,
             rsp_result, rsp_check} !== '0) begin
            n_fail++;
            $display("FAIL t6_async: grant=%b done=%b err=%b result_c=%0d rsp=%0d/%0d, expected all 0",
                     grant, done, err, result_c, rsp_result, rsp_check);
        end
        tick();
        RST = 1'b0;
        RDY_result = 1'b1;
        fix_result = 5'd21;
        fix_check  = 5'd30;
        set_args(1, 5'd2, 5'd5, 5'd1, 5'd3);
        req = 2'b10;
        push_exp(req, 1'b0, 5'd21, 5'd30, 5'd21, 5'd30);
        wait_end(10, n);
        e = sb.pop_front();
        n_tests++;
        if ({done, err, grant, rsp_result, rsp_check} !== {1'b1, 1'b0, e.g, e.r, e.c} || n != 4) begin
            n_fail++;
            $display("FAIL t6_after: done=%b err=%b grant=%b rsp=%0d/%0d after %0d cycles, expected 1 0 %b %0d/%0d after 4",
                     done, err, grant, rsp_result, rsp_check, n, e.g, e.r, e.c);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_fairness();
        exp_t e;
        int   n;
        use_model = 1'b1;
        set_args(0, 5'd1, 5'd2, 5'd3, 5'd4);
        set_args(1, 5'd10, 5'd11, 5'd12, 5'd13);
        req = 2'b11;
        repeat (4) push_exp(req, 1'b0, 5'd6, 5'd7, 5'd1, 5'd24);
        for (int t = 0; t < 4; t++) begin
            wait_end(20, n);
            e = sb.pop_front();
            n_tests++;
            if ({done, err, grant, rsp_result, rsp_check} !== {1'b1, 1'b0, e.g, e.r, e.c}
                || n != ((t == 0) ? 4 : 5)) begin
                n_fail++;
                $display("FAIL t2_txn%0d: done=%b err=%b grant=%b rsp=%0d/%0d after %0d cycles, expected 1 0 %b %0d/%0d",
                         t, done, err, grant, rsp_result, rsp_check, n, e.g, e.r, e.c);
            end
            if (t == 3) req = 2'b00;
        end
        tick();
        n_tests++;
        if ({grant, done} !== 3'd0) begin
            n_fail++;
            $display("FAIL t2_idle: grant=%b done=%b, expected 00 0", grant, done);
        end
        use_model = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        req        = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        req_d      = '0;
        RDY_start  = 1'b1;
        RDY_result = 1'b1;
        RDY_check  = 1'b1;
        use_model  = 1'b0;
        fix_result = 5'd0;
        fix_check  = 5'd0;

        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_arg_latch();
        test_reset_mid();
        test_fairness();

        n_tests++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL enable_overlap: %0d bad enable cycles, expected 0", viol);
        end
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
